// File: rtl/ant_frame_scheduler.sv
// ---------------------------------------------------------------------------
// ant_frame_scheduler
//
// Per-frame sequencer for the ant update and draw engines. On each frame tick
// it walks ant ids 0..count-1. For every id it starts the update engine, waits
// for it, then starts the draw engine and waits for that. It owns the single
// datapath request port and steers the active engine onto it.
//
// Ports
//   clock, resetn           : clock, synchronous active-low reset
//   enable                  : run frames while high
//   frame_tick              : one-cycle frame pulse
//   ant_count               : live ants, sampled when a frame starts
//   ant_id                  : id presented to both engines
//   upd_start/upd_finished  : update engine handshake
//   upd_start_dp/upd_instruction_dp : update engine datapath request
//   drw_start/drw_finished  : draw engine handshake
//   drw_start_dp/drw_instruction_dp : draw engine datapath request
//   start_dp/instruction_dp : muxed datapath request
//   finished_dp_in/out      : datapath completion, passed to both engines
//   busy                    : walking ants (not IDLE/WAIT_TICK)
//   frame_done              : one-cycle pulse when a frame completes
//   frame_count             : completed frames, wraps
//   overrun                 : sticky, tick arrived while one already pending
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module ant_frame_scheduler #(
    parameter int ID_WIDTH        = `MEM_ADDR_WIDTH,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic                          frame_tick,
    input  logic [ID_WIDTH-1:0]           ant_count,
    output logic [ID_WIDTH-1:0]           ant_id,
    output logic                          upd_start,
    input  logic                          upd_finished,
    input  logic                          upd_start_dp,
    input  logic [`INSTRUCTION_WIDTH-1:0] upd_instruction_dp,
    output logic                          drw_start,
    input  logic                          drw_finished,
    input  logic                          drw_start_dp,
    input  logic [`INSTRUCTION_WIDTH-1:0] drw_instruction_dp,
    output logic                          start_dp,
    output logic [`INSTRUCTION_WIDTH-1:0] instruction_dp,
    input  logic                          finished_dp_in,
    output logic                          finished_dp_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]    frame_count,
    output logic                          overrun
);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_TICK,
        UPD_GO,
        UPD_ARM,
        UPD_WAIT,
        DRW_GO,
        DRW_ARM,
        DRW_WAIT,
        NEXT
    } state_t;

    localparam logic [ID_WIDTH-1:0]        ID_ONE = 1;
    localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE = 1;

    state_t                     state_reg, state_next;
    logic [ID_WIDTH-1:0]        ant_id_reg, ant_id_next;
    logic [ID_WIDTH-1:0]        count_reg, count_next;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_reg, frame_count_next;
    logic                       pending_reg, pending_next;
    logic                       overrun_reg, overrun_next;
    logic                       frame_done_reg, frame_done_next;
    logic                       busy_state;

    assign busy_state = (state_reg != IDLE) && (state_reg != WAIT_TICK);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            ant_id_reg      <= '0;
            count_reg       <= '0;
            frame_count_reg <= '0;
            pending_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ant_id_reg      <= ant_id_next;
            count_reg       <= count_next;
            frame_count_reg <= frame_count_next;
            pending_reg     <= pending_next;
            overrun_reg     <= overrun_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ant_id_next      = ant_id_reg;
        count_next       = count_reg;
        frame_count_next = frame_count_reg;
        pending_next     = pending_reg;
        overrun_next     = overrun_reg;
        frame_done_next  = 1'b0;

        // A tick while walking ants is remembered; a second one is an overrun.
        if (frame_tick && busy_state) begin
            pending_next = 1'b1;
            if (pending_reg) begin
                overrun_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next   = WAIT_TICK;
                    pending_next = 1'b0;
                end
            end
            WAIT_TICK: begin
                // A tick arriving together with a pending one is consumed by
                // the same frame start.
                if (frame_tick || pending_reg) begin
                    pending_next = 1'b0;
                    count_next   = ant_count;
                    ant_id_next  = '0;
                    if (ant_count == '0) begin
                        frame_done_next  = 1'b1;
                        frame_count_next = frame_count_reg + FC_ONE;
                        state_next       = enable ? WAIT_TICK : IDLE;
                    end else begin
                        state_next = UPD_GO;
                    end
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            UPD_GO:   state_next = UPD_ARM;
            // finished is still high while the engine reacts to its start.
            UPD_ARM:  state_next = UPD_WAIT;
            UPD_WAIT: if (upd_finished) state_next = DRW_GO;
            DRW_GO:   state_next = DRW_ARM;
            DRW_ARM:  state_next = DRW_WAIT;
            DRW_WAIT: if (drw_finished) state_next = NEXT;
            NEXT: begin
                if (ant_id_reg == count_reg - ID_ONE) begin
                    frame_done_next  = 1'b1;
                    frame_count_next = frame_count_reg + FC_ONE;
                    ant_id_next      = '0;
                    state_next       = enable ? WAIT_TICK : IDLE;
                end else begin
                    ant_id_next = ant_id_reg + ID_ONE;
                    state_next  = UPD_GO;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath request steering follows the engine that owns the state.
    always_comb begin
        start_dp       = 1'b0;
        instruction_dp = '0;
        case (state_reg)
            UPD_GO, UPD_ARM, UPD_WAIT: begin
                start_dp       = upd_start_dp;
                instruction_dp = upd_instruction_dp;
            end
            DRW_GO, DRW_ARM, DRW_WAIT: begin
                start_dp       = drw_start_dp;
                instruction_dp = drw_instruction_dp;
            end
            default: begin
                start_dp       = 1'b0;
                instruction_dp = '0;
            end
        endcase
    end

    assign upd_start       = (state_reg == UPD_GO);
    assign drw_start       = (state_reg == DRW_GO);
    assign ant_id          = ant_id_reg;
    assign busy            = busy_state;
    assign frame_done      = frame_done_reg;
    assign frame_count     = frame_count_reg;
    assign overrun         = overrun_reg;
    assign finished_dp_out = finished_dp_in;

endmodule

// File: tb/tb_ant_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ant_frame_scheduler
//
// Directed bench. Two engine models answer the start strobes:
//   update engine: drops finished on the edge that samples upd_start and keeps
//                  it low for TU cycles.
//   draw engine:   registers drw_start first (finished still high during
//                  DRW_ARM), then keeps finished low for TD cycles.
// With TU=4, TD=10 one ant takes 20 cycles, so a frame of N ants shows
// frame_done N*20+1 cycles after the tick cycle.
// ---------------------------------------------------------------------------
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module tb_ant_frame_scheduler;

    localparam int ID_W = 8;
    localparam int FC_W = 16;
    localparam int IW   = `INSTRUCTION_WIDTH;
    localparam int TU   = 4;
    localparam int TD   = 10;

    logic            clock;
    logic            resetn;
    logic            enable;
    logic            frame_tick;
    logic [ID_W-1:0] ant_count;
    logic [ID_W-1:0] ant_id;
    logic            upd_start;
    logic            upd_finished;
    logic            upd_start_dp;
    logic [IW-1:0]   upd_instruction_dp;
    logic            drw_start;
    logic            drw_finished;
    logic            drw_start_dp;
    logic [IW-1:0]   drw_instruction_dp;
    logic            start_dp;
    logic [IW-1:0]   instruction_dp;
    logic            finished_dp_in;
    logic            finished_dp_out;
    logic            busy;
    logic            frame_done;
    logic [FC_W-1:0] frame_count;
    logic            overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    ant_frame_scheduler #(
        .ID_WIDTH        (ID_W),
        .FRAME_CNT_WIDTH (FC_W)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .enable             (enable),
        .frame_tick         (frame_tick),
        .ant_count          (ant_count),
        .ant_id             (ant_id),
        .upd_start          (upd_start),
        .upd_finished       (upd_finished),
        .upd_start_dp       (upd_start_dp),
        .upd_instruction_dp (upd_instruction_dp),
        .drw_start          (drw_start),
        .drw_finished       (drw_finished),
        .drw_start_dp       (drw_start_dp),
        .drw_instruction_dp (drw_instruction_dp),
        .start_dp           (start_dp),
        .instruction_dp     (instruction_dp),
        .finished_dp_in     (finished_dp_in),
        .finished_dp_out    (finished_dp_out),
        .busy               (busy),
        .frame_done         (frame_done),
        .frame_count        (frame_count),
        .overrun            (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Update engine model.
    int upd_cnt_m;
    always @(posedge clock) begin
        if (!resetn) begin
            upd_finished <= 1'b1;
            upd_cnt_m    <= 0;
        end else if (upd_start) begin
            upd_finished <= 1'b0;
            upd_cnt_m    <= TU;
        end else if (!upd_finished) begin
            if (upd_cnt_m == 1) upd_finished <= 1'b1;
            upd_cnt_m <= upd_cnt_m - 1;
        end
    end

    // Draw engine model (registered start strobe).
    int   drw_cnt_m;
    logic drw_go_q;
    always @(posedge clock) begin
        if (!resetn) begin
            drw_finished <= 1'b1;
            drw_go_q     <= 1'b0;
            drw_cnt_m    <= 0;
        end else begin
            drw_go_q <= drw_start;
            if (drw_go_q) begin
                drw_finished <= 1'b0;
                drw_cnt_m    <= TD;
            end else if (!drw_finished) begin
                if (drw_cnt_m == 1) drw_finished <= 1'b1;
                drw_cnt_m <= drw_cnt_m - 1;
            end
        end
    end

    // Strobe monitor: pulse counts and the ids seen at each strobe.
    int              upd_cnt = 0;
    int              drw_cnt = 0;
    int              done_cnt = 0;
    logic [4*ID_W-1:0] upd_seq = '0;
    logic [4*ID_W-1:0] drw_seq = '0;
    always @(negedge clock) begin
        if (upd_start) begin
            upd_cnt <= upd_cnt + 1;
            upd_seq <= {upd_seq[3*ID_W-1:0], ant_id};
        end
        if (drw_start) begin
            drw_cnt <= drw_cnt + 1;
            drw_seq <= {drw_seq[3*ID_W-1:0], ant_id};
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk(tag, frame_done, 1);
    endtask

    localparam logic [3*ID_W-1:0] SEQ_012 = {8'd0, 8'd1, 8'd2};

    int t0;
    int upd0;
    int drw0;
    int done0;

    initial begin
        resetn             = 1'b0;
        enable             = 1'b0;
        frame_tick         = 1'b0;
        ant_count          = '0;
        upd_start_dp       = 1'b1;
        drw_start_dp       = 1'b1;
        upd_instruction_dp = IW'(32'hDEAD_BEEF);
        drw_instruction_dp = IW'(32'hCAFE_F00D);
        finished_dp_in     = 1'b0;
        step(3);

        // Reset state: everything low, mux closed even with engine requests up.
        chk("rst_busy", busy, 0);
        chk("rst_ant_id", ant_id, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_starts", {upd_start, drw_start}, 0);
        chk("rst_start_dp", start_dp, 0);
        chk("rst_instr_dp", instruction_dp, 0);
        finished_dp_in = 1'b1;
        #1;
        chk("fin_dp_pass1", finished_dp_out, 1);
        finished_dp_in = 1'b0;
        #1;
        chk("fin_dp_pass0", finished_dp_out, 0);
        upd_start_dp       = 1'b0;
        drw_start_dp       = 1'b0;
        upd_instruction_dp = '0;
        drw_instruction_dp = '0;

        // A: three-ant frame.
        resetn    = 1'b1;
        enable    = 1'b1;
        ant_count = 8'd3;
        step(2);
        upd0 = upd_cnt; drw0 = drw_cnt; done0 = done_cnt;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        chk("a_first_upd_start", upd_start, 1);
        chk("a_first_id", ant_id, 0);
        chk("a_busy", busy, 1);
        wait_done("a_done_seen", 200);
        chk("a_done_cycle", cyc - t0, 61);
        chk("a_frame_count", frame_count, 1);
        step(1);
        chk("a_done_width", frame_done, 0);
        chk("a_upd_pulses", upd_cnt - upd0, 3);
        chk("a_drw_pulses", drw_cnt - drw0, 3);
        chk("a_upd_ids", upd_seq[3*ID_W-1:0], SEQ_012);
        chk("a_drw_ids", drw_seq[3*ID_W-1:0], SEQ_012);
        chk("a_overrun", overrun, 0);
        chk("a_idle_busy", busy, 0);

        // B: empty frame completes the cycle after the tick.
        step(2);
        upd0 = upd_cnt;
        ant_count  = 8'd0;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        chk("b_done", frame_done, 1);
        chk("b_frame_count", frame_count, 2);
        chk("b_busy", busy, 0);
        step(2);
        chk("b_done_width", frame_done, 0);
        chk("b_no_starts", upd_cnt - upd0, 0);

        // C: two extra ticks during a frame -> overrun, one extra frame.
        ant_count = 8'd3;
        done0 = done_cnt;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        step(9);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        chk("c_pending_no_overrun", overrun, 0);
        step(19);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        chk("c_overrun", overrun, 1);
        wait_done("c_done1_seen", 200);
        chk("c_done1_cycle", cyc - t0, 61);
        step(1);
        chk("c_back_to_back", busy, 1);
        wait_done("c_done2_seen", 200);
        chk("c_done2_cycle", cyc - t0, 122);
        step(30);
        chk("c_no_third", busy, 0);
        chk("c_frame_count", frame_count, 4);
        chk("c_done_pulses", done_cnt - done0, 2);
        chk("c_overrun_sticky", overrun, 1);

        // D: datapath steering for a one-ant frame.
        ant_count = 8'd1;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        step(2);
        upd_start_dp       = 1'b0;
        drw_start_dp       = 1'b1;
        upd_instruction_dp = IW'(32'h1111_2222);
        drw_instruction_dp = IW'(32'hA5C3_0F96);
        #1;
        chk("d_upd_wait_start_dp", start_dp, 0);
        chk("d_upd_wait_instr", instruction_dp, IW'(32'h1111_2222));
        upd_start_dp = 1'b1;
        #1;
        chk("d_upd_wait_start_dp1", start_dp, 1);
        step(6);
        chk("d_drw_wait_instr", instruction_dp, IW'(32'hA5C3_0F96));
        chk("d_drw_wait_start_dp", start_dp, 1);
        drw_start_dp = 1'b0;
        #1;
        chk("d_drw_wait_start_dp0", start_dp, 0);
        drw_start_dp = 1'b1;
        wait_done("d_done_seen", 100);
        chk("d_done_cycle", cyc - t0, 21);
        chk("d_frame_count", frame_count, 5);
        step(1);
        chk("d_closed_start_dp", start_dp, 0);
        chk("d_closed_instr", instruction_dp, 0);
        upd_start_dp       = 1'b0;
        drw_start_dp       = 1'b0;
        upd_instruction_dp = '0;
        drw_instruction_dp = '0;

        // E: enable drops during ant 1; frame still completes, then IDLE.
        ant_count = 8'd3;
        upd0 = upd_cnt; drw0 = drw_cnt;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        step(24);
        chk("e_on_ant1", ant_id, 1);
        enable = 1'b0;
        wait_done("e_done_seen", 200);
        chk("e_done_cycle", cyc - t0, 61);
        chk("e_frame_count", frame_count, 6);
        step(1);
        chk("e_upd_pulses", upd_cnt - upd0, 3);
        chk("e_drw_ids", drw_seq[3*ID_W-1:0], SEQ_012);
        chk("e_idle", busy, 0);
        upd0 = upd_cnt;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(5);
        chk("e_tick_ignored", busy, 0);
        enable = 1'b1;
        step(6);
        chk("e_tick_discarded", busy, 0);
        chk("e_count_held", frame_count, 6);
        chk("e_no_starts", upd_cnt - upd0, 0);

        // F: reset during DRW_WAIT of ant 2 abandons the frame.
        done0 = done_cnt;
        frame_tick = 1'b1; t0 = cyc;
        step(1);
        frame_tick = 1'b0;
        step(51);
        chk("f_on_ant2", ant_id, 2);
        drw_start_dp       = 1'b1;
        drw_instruction_dp = IW'(32'h0BAD_F00D);
        #1;
        chk("f_drw_start_dp", start_dp, 1);
        resetn = 1'b0;
        step(1);
        chk("f_busy", busy, 0);
        chk("f_ant_id", ant_id, 0);
        chk("f_frame_count", frame_count, 0);
        chk("f_overrun", overrun, 0);
        chk("f_outputs", {frame_done, upd_start, drw_start, start_dp}, 0);
        chk("f_instr", instruction_dp, 0);
        resetn = 1'b1;
        step(20);
        chk("f_no_done", done_cnt - done0, 0);
        chk("f_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
